// File: rtl/uart_tx_fifo_pkg.sv
// uart_pkg: FSM state encoding and default timing parameters shared by the UART TX FIFO
package uart_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_WAIT_ACK, ST_WAIT_DONE, ST_GAP} tx_state_e;
  localparam int ACK_TIMEOUT_DEF = 15;
  localparam int GAP_CYCLES_DEF = 0;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer and transmitter signals of uart_tx_fifo
// master drives flush/in_data/in_valid/tx_busy; slave (the FIFO) drives the rest
interface uart_tx_fifo_if #(parameter int DEPTH = 16) ();
  logic                     flush;
  logic [7:0]               in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     tx_busy;
  logic [7:0]               tx_data;
  logic                     tx_start;
  logic [$clog2(DEPTH):0]   level;
  logic                     empty;
  logic                     idle;
  logic                     timeout_err;
  modport master (output flush, in_data, in_valid, tx_busy,
                  input in_ready, tx_data, tx_start, level, empty, idle, timeout_err);
  modport slave (input flush, in_data, in_valid, tx_busy,
                 output in_ready, tx_data, tx_start, level, empty, idle, timeout_err);
endinterface

// File: rtl/uart_tx_fifo_byte_fifo.sv
// byte_fifo: byte FIFO with registered level and synchronous flush
// ports: clk, rst_n (async, active-low), flush, push, pop, wdata -> rdata (head), full, empty, level
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             wdata,
  output logic [7:0]             rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;
  // full refuses a push even when a pop happens in the same cycle
  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(do_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(do_pop);
    level_d  = flush ? '0 : level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end
  assign rdata = mem[rd_ptr_q];
  assign full  = level_q == (AW+1)'(DEPTH);
  assign empty = level_q == '0;
  assign level = level_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffers producer bytes and hands them one at a time to a UART transmitter
// ports: clk, rst_n (async, active-low), bus (slave modport: producer handshake, flush,
// transmitter start/busy handshake, level/empty/idle status, sticky timeout_err)
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int CMAX = ACK_TIMEOUT > GAP_CYCLES ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1) + 1;
  tx_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [7:0]             tx_data_q, tx_data_d, head;
  logic                   err_q, err_d, pop, full, empty;
  logic [$clog2(DEPTH):0] level;
  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.flush),
    .push  (bus.in_valid),
    .pop   (pop),
    .wdata (bus.in_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );
  // one counter serves both the ack timeout and the inter-byte gap
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    err_d     = err_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!empty && !bus.flush) begin
          pop       = 1'b1;
          tx_data_d = head;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (bus.tx_busy) state_d = ST_WAIT_DONE;
        else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_GAP;
        end else cnt_d = cnt_q + CW'(1);
      end
      ST_WAIT_DONE: begin
        cnt_d   = '0;
        state_d = bus.tx_busy ? ST_WAIT_DONE : ST_GAP;
      end
      ST_GAP: begin
        if (GAP_CYCLES == 0 || cnt_q == CW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
        else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
    end
  end
  assign bus.in_ready    = !full;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = state_q == ST_START;
  assign bus.level       = level;
  assign bus.empty       = empty;
  assign bus.idle        = empty && state_q == ST_IDLE;
  assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: random and directed stimulus checked against a timestamp-based queue model
module tb_uart_tx_fifo;
  localparam int DEPTH = 16, GAP = 0, ACK = 15;
  localparam int GAPX = GAP > 0 ? GAP : 1;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();
  uart_tx_fifo #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // transmitter model: busy rises the cycle after tx_start and stays high busy_len cycles
  int busy_mode = 0, busy_len = 10, busy_cnt = 0;
  bit arm = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      arm = 0;
    end else begin
      if (busy_cnt > 0) busy_cnt--;
      if (arm) begin
        busy_cnt = busy_len;
        arm = 0;
      end
      if (bus.tx_start === 1'b1) arm = 1;
    end
    bus.tx_busy = busy_mode == 1 ? 1'b1 : busy_mode == 2 ? 1'b0 : busy_cnt > 0;
  end
  // reference model: byte queue plus edge timestamps of pop, ack window and sender release
  logic [7:0] q[$];
  int cyc = 0, pop_e = 0, free_e = 0, n;
  bit in_flight = 0, acked = 0, m_start = 0, m_err = 0, do_pop, do_push;
  logic [7:0] m_data = 8'h00;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cyc = 0; pop_e = 0; free_e = 0;
      in_flight = 0; acked = 0; m_start = 0; m_err = 0; m_data = 8'h00;
    end else begin
      cyc++;
      n = q.size();
      m_start = 0;
      if (in_flight && !acked && cyc >= pop_e + 2) begin
        if (bus.tx_busy) acked = 1;
        else if (cyc == pop_e + 1 + ACK) begin
          m_err = 1; in_flight = 0; free_e = cyc + GAPX + 1;
        end
      end else if (in_flight && acked && !bus.tx_busy) begin
        in_flight = 0; free_e = cyc + GAPX + 1;
      end
      do_pop  = !in_flight && cyc >= free_e && n > 0 && !bus.flush;
      do_push = bus.in_valid && n < DEPTH && !bus.flush;
      if (bus.flush) q.delete();
      if (do_pop) begin
        m_data = q.pop_front(); in_flight = 1; acked = 0; pop_e = cyc; m_start = 1;
      end
      if (do_push) q.push_back(bus.in_data);
    end
  end
  logic [7:0] sent[$];
  int start_cyc[$];
  bit chk_en = 0;
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("level", bus.level, q.size());
      chk("empty", bus.empty, q.size() == 0);
      chk("in_ready", bus.in_ready, q.size() < DEPTH);
      chk("tx_start", bus.tx_start, m_start);
      chk("tx_data", bus.tx_data, m_data);
      chk("idle", bus.idle, q.size() == 0 && !in_flight && cyc >= free_e - 1);
      chk("timeout_err", bus.timeout_err, m_err);
      if (bus.tx_start === 1'b1) begin
        sent.push_back(bus.tx_data);
        start_cyc.push_back(cyc);
      end
    end
  end
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic push(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_idle(input int lim, input string name);
    for (int i = 0; i < lim && bus.idle !== 1'b1; i++) @(negedge clk);
    chk(name, bus.idle, 1);
  endtask
  task automatic wait_start(input int lim, input string name);
    for (int i = 0; i < lim && bus.tx_start !== 1'b1; i++) @(negedge clk);
    chk(name, bus.tx_start, 1);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_level"}, bus.level, 0);
    chk({tag, "_empty"}, bus.empty, 1);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_tx_data"}, bus.tx_data, 8'h00);
    chk({tag, "_tx_start"}, bus.tx_start, 0);
    chk({tag, "_idle"}, bus.idle, 1);
    chk({tag, "_timeout_err"}, bus.timeout_err, 0);
  endtask
  logic [7:0] ccnu [4] = '{8'h43, 8'h43, 8'h4E, 8'h55};
  initial begin
    int k;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.flush = 1'b0;
    tick(3);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    chk_en = 1;
    tick(2);
    // single byte: tx_start two cycles after the push cycle, idle 13 cycles after tx_start
    sent.delete();
    push(8'h43);
    chk("t1_level", bus.level, 1);
    chk("t1_start_early", bus.tx_start, 0);
    tick(1);
    chk("t1_start", bus.tx_start, 1);
    chk("t1_data", bus.tx_data, 8'h43);
    tick(12);
    chk("t1_idle_c12", bus.idle, 0);
    tick(1);
    chk("t1_idle_c13", bus.idle, 1);
    // back-to-back burst
    sent.delete();
    start_cyc.delete();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = ccnu[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("t2_level", bus.level, 3);
    wait_idle(300, "t2_idle");
    tick(1);
    chk("t2_count", sent.size(), 4);
    for (int i = 0; i < 4 && i < sent.size(); i++) chk("t2_byte", sent[i], ccnu[i]);
    for (int i = 1; i < start_cyc.size(); i++)
      chk("t2_spacing", start_cyc[i] - start_cyc[i-1] >= busy_len + GAP + 3, 1);
    // fill while the transmitter is stuck busy
    busy_mode = 1;
    sent.delete();
    k = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40 && bus.in_ready === 1'b1; i++) begin
      bus.in_data = 8'(8'h60 + k);
      k++;
      @(negedge clk);
    end
    bus.in_data = 8'(8'h60 + k);
    chk("t3_level_full", bus.level, 16);
    chk("t3_ready_low", bus.in_ready, 0);
    chk("t3_accepted", k, 17);
    tick(3);
    chk("t3_refused", bus.level, 16);
    busy_mode = 0;
    for (int i = 0; i < 40 && bus.level !== 15; i++) @(negedge clk);
    chk("t3_pop", bus.level, 15);
    chk("t3_ready_after_pop", bus.in_ready, 1);
    tick(1);
    chk("t3_refill", bus.level, 16);
    bus.in_valid = 1'b0;
    wait_idle(1500, "t3_idle");
    tick(1);
    chk("t3_count", sent.size(), 18);
    if (sent.size() == 18) chk("t3_last", sent[17], 8'h71);
    // acknowledge timeout
    busy_mode = 2;
    sent.delete();
    push(8'h50);
    tick(1);
    chk("t4_start", bus.tx_start, 1);
    tick(15);
    chk("t4_err_before", bus.timeout_err, 0);
    tick(1);
    chk("t4_err_set", bus.timeout_err, 1);
    chk("t4_gap_not_idle", bus.idle, 0);
    tick(1);
    chk("t4_idle", bus.idle, 1);
    busy_mode = 0;
    push(8'h51);
    wait_start(10, "t4_next_start");
    chk("t4_next_data", bus.tx_data, 8'h51);
    wait_idle(100, "t4_idle_after");
    chk("t4_err_sticky", bus.timeout_err, 1);
    // flush while the first byte is in WAIT_DONE
    sent.delete();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 8'(8'h70 + i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    chk("t5_flushed", bus.level, 0);
    bus.in_valid = 1'b1;
    bus.in_data = 8'hAA;
    bus.flush = 1'b1;
    tick(1);
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    chk("t5_push_flush", bus.level, 0);
    tick(40);
    chk("t5_count", sent.size(), 1);
    if (sent.size() > 0) chk("t5_byte", sent[0], 8'h70);
    chk("t5_idle", bus.idle, 1);
    // randomized traffic with occasional flushes and silent-transmitter periods
    for (int i = 0; i < 1200; i++) begin
      busy_len = $urandom_range(1, 12);
      busy_mode = (i % 300 >= 260) ? 2 : 0;
      bus.in_valid = ($urandom % 4) != 0;
      bus.in_data = 8'($urandom);
      bus.flush = ($urandom % 80) == 0;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    busy_mode = 0;
    busy_len = 10;
    wait_idle(3000, "t6_idle");
    // asynchronous reset during WAIT_DONE
    push(8'h31);
    push(8'h32);
    tick(5);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t7_async");
    @(negedge clk);
    chk("t7_start_in_reset", bus.tx_start, 0);
    @(negedge clk);
    chk("t7_start_in_reset2", bus.tx_start, 0);
    sent.delete();
    #2 rst_n = 1'b1;
    tick(31);
    chk("t7_no_start", sent.size(), 0);
    chk("t7_idle", bus.idle, 1);
    push(8'h7E);
    wait_start(5, "t7_new_start");
    chk("t7_new_data", bus.tx_data, 8'h7E);
    wait_idle(100, "t7_idle_end");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end
endmodule
